// File: rtl/branch_predictor_if.sv
// Fetch/decode-side signal bundle for the BTB branch predictor.
// The master is the pipeline (driver of PCs and outcomes); the slave is the predictor.
interface branch_predictor_if #(
    parameter int PERF_WIDTH = 16
);
    logic [31:0]           IF_pc;
    logic                  IF_stall;
    logic                  flushD;
    logic                  IF_pred_taken;
    logic [31:0]           IF_pred_target;
    logic [31:0]           ID_pc;
    logic                  ID_is_branch;
    logic                  ID_hold;
    logic                  ID_taken;
    logic [31:0]           ID_target;
    logic                  ID_misprediction;
    logic [31:0]           ID_correct_pc;
    logic [PERF_WIDTH-1:0] perf_branches;
    logic [PERF_WIDTH-1:0] perf_mispredicts;

    modport master (
        output IF_pc, IF_stall, flushD, ID_pc, ID_is_branch, ID_hold, ID_taken, ID_target,
        input  IF_pred_taken, IF_pred_target, ID_misprediction, ID_correct_pc,
               perf_branches, perf_mispredicts
    );

    modport slave (
        input  IF_pc, IF_stall, flushD, ID_pc, ID_is_branch, ID_hold, ID_taken, ID_target,
        output IF_pred_taken, IF_pred_target, ID_misprediction, ID_correct_pc,
               perf_branches, perf_mispredicts
    );
endinterface

// File: rtl/branch_predictor.sv
// IF-stage dynamic branch predictor: direct-mapped BTB with 2-bit saturating
// counters, an IF/ID copy of the prediction, ID-stage misprediction resolution
// and saturating performance counters.
module branch_predictor #(
    parameter int INDEX_WIDTH = 4,
    parameter int PERF_WIDTH  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    branch_predictor_if.slave  bp
);
    localparam int ENTRIES = 2 ** INDEX_WIDTH;
    localparam int TAG_W   = 32 - INDEX_WIDTH - 2;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        logic [1:0]       ctr;
    } btb_entry_t;

    btb_entry_t btb [ENTRIES];

    logic [INDEX_WIDTH-1:0] if_idx, id_idx;
    logic [TAG_W-1:0]       if_tag, id_tag;
    logic                   if_hit, id_hit;
    logic                   pred_taken;
    logic [31:0]            pred_target;
    logic                   p_taken;
    logic [31:0]            p_target;
    logic                   mispredict;
    logic [PERF_WIDTH-1:0]  perf_b, perf_m;
    logic                   unused_pc_bits;

    assign if_idx = bp.IF_pc[INDEX_WIDTH+1:2];
    assign if_tag = bp.IF_pc[31:INDEX_WIDTH+2];
    assign id_idx = bp.ID_pc[INDEX_WIDTH+1:2];
    assign id_tag = bp.ID_pc[31:INDEX_WIDTH+2];

    // PCs are word aligned, the low bits carry no information
    assign unused_pc_bits = ^{bp.IF_pc[1:0], bp.ID_pc[1:0]};

    // Zero-latency lookup; sees pre-update table contents (no bypass)
    always_comb begin
        if_hit      = btb[if_idx].valid && (btb[if_idx].tag == if_tag);
        pred_taken  = if_hit && btb[if_idx].ctr[1];
        pred_target = pred_taken ? btb[if_idx].target : bp.IF_pc + 32'd4;
    end

    assign bp.IF_pred_taken  = pred_taken;
    assign bp.IF_pred_target = pred_target;

    // IF/ID prediction copy: flush beats stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_taken  <= 1'b0;
            p_target <= 32'd0;
        end else if (bp.flushD) begin
            p_taken  <= 1'b0;
            p_target <= 32'd0;
        end else if (!bp.IF_stall) begin
            p_taken  <= pred_taken;
            p_target <= pred_target;
        end
    end

    // ID resolution; a predicted-taken non-branch is a stale or aliased hit
    always_comb begin
        id_hit     = btb[id_idx].valid && (btb[id_idx].tag == id_tag);
        mispredict = 1'b0;
        if (!bp.ID_hold) begin
            if (bp.ID_is_branch)
                mispredict = (p_taken != bp.ID_taken) ||
                             (p_taken && bp.ID_taken && (p_target != bp.ID_target));
            else
                mispredict = p_taken;
        end
    end

    assign bp.ID_misprediction = mispredict;
    assign bp.ID_correct_pc    = (bp.ID_is_branch && bp.ID_taken) ? bp.ID_target
                                                                  : bp.ID_pc + 32'd4;

    // Table training from ID outcomes; frozen while ID operands are pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++)
                btb[i] <= '{valid: 1'b0, tag: '0, target: 32'd0, ctr: 2'b01};
        end else if (!bp.ID_hold) begin
            if (bp.ID_is_branch) begin
                if (id_hit) begin
                    if (bp.ID_taken) begin
                        btb[id_idx].target <= bp.ID_target;
                        if (btb[id_idx].ctr != 2'b11)
                            btb[id_idx].ctr <= btb[id_idx].ctr + 2'd1;
                    end else if (btb[id_idx].ctr != 2'b00) begin
                        btb[id_idx].ctr <= btb[id_idx].ctr - 2'd1;
                    end
                end else if (bp.ID_taken) begin
                    btb[id_idx] <= '{valid: 1'b1, tag: id_tag, target: bp.ID_target, ctr: 2'b10};
                end
            end else if (p_taken) begin
                btb[id_idx].valid <= 1'b0;
            end
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_b <= '0;
            perf_m <= '0;
        end else begin
            if (!bp.ID_hold && bp.ID_is_branch && (perf_b != '1))
                perf_b <= perf_b + PERF_WIDTH'(1);
            if (mispredict && (perf_m != '1))
                perf_m <= perf_m + PERF_WIDTH'(1);
        end
    end

    assign bp.perf_branches    = perf_b;
    assign bp.perf_mispredicts = perf_m;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: stimulus pushes hand-computed
// expectations into a queue, a negedge monitor pops and compares them.
module tb_branch_predictor;
    localparam int K_PT = 0, K_TGT = 1, K_MIS = 2, K_CPC = 3, K_PB = 4, K_PM = 5;

    typedef struct {
        int          kind;
        logic [31:0] val;
        int          step;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   stp = 0;
    exp_t q[$];

    branch_predictor_if #(.PERF_WIDTH(16)) bp_if();

    branch_predictor #(.INDEX_WIDTH(4), .PERF_WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bp_if.slave)
    );

    always #5 clk = ~clk;

    function automatic string kname(int k);
        case (k)
            K_PT:    return "IF_pred_taken";
            K_TGT:   return "IF_pred_target";
            K_MIS:   return "ID_misprediction";
            K_CPC:   return "ID_correct_pc";
            K_PB:    return "perf_branches";
            default: return "perf_mispredicts";
        endcase
    endfunction

    function automatic logic [31:0] actual(int k);
        case (k)
            K_PT:    return {31'd0, bp_if.IF_pred_taken};
            K_TGT:   return bp_if.IF_pred_target;
            K_MIS:   return {31'd0, bp_if.ID_misprediction};
            K_CPC:   return bp_if.ID_correct_pc;
            K_PB:    return {16'd0, bp_if.perf_branches};
            default: return {16'd0, bp_if.perf_mispredicts};
        endcase
    endfunction

    // Monitor: compare every queued expectation against the settled outputs
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (q.size() > 0) begin
            e   = q.pop_front();
            act = actual(e.kind);
            n_tests++;
            if (act !== e.val) begin
                n_fail++;
                $display("FAIL %s step %0d: got %h expected %h", kname(e.kind), e.step, act, e.val);
            end
        end
    end

    task automatic push(int k, logic [31:0] v);
        exp_t e;
        e.kind = k; e.val = v; e.step = stp;
        q.push_back(e);
    endtask

    task automatic chk_if(logic pt, logic [31:0] tgt);
        push(K_PT, {31'd0, pt});
        push(K_TGT, tgt);
    endtask

    task automatic chk_id(logic mis, logic [31:0] cpc);
        push(K_MIS, {31'd0, mis});
        push(K_CPC, cpc);
    endtask

    task automatic chk_perf(int b, int m);
        push(K_PB, 32'(b));
        push(K_PM, 32'(m));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        stp++;
        bp_if.IF_stall = 1'b0;
        bp_if.flushD   = 1'b0;
    endtask

    task automatic drive(logic [31:0] if_pc, logic [31:0] id_pc, logic br, logic hold,
                         logic taken, logic [31:0] tgt);
        bp_if.IF_pc        = if_pc;
        bp_if.ID_pc        = id_pc;
        bp_if.ID_is_branch = br;
        bp_if.ID_hold      = hold;
        bp_if.ID_taken     = taken;
        bp_if.ID_target    = tgt;
    endtask

    initial begin
        bp_if.IF_stall = 1'b0;
        bp_if.flushD   = 1'b0;
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

        // Reset state
        step(); drive(32'h0040_0010, 0, 0, 0, 0, 0);
        chk_if(0, 32'h0040_0014); chk_id(0, 32'h4); chk_perf(0, 0);

        step(); rst_n = 1'b1; drive(32'h0040_0020, 0, 0, 0, 0, 0);
        chk_if(0, 32'h0040_0024); chk_id(0, 32'h4);

        // Cold taken beq: mispredict, allocate with ctr=2
        step(); drive(32'h0040_0000, 32'h0040_0020, 1, 0, 1, 32'h0040_0000);
        chk_id(1, 32'h0040_0000);

        step(); drive(32'h0040_0020, 0, 0, 0, 0, 0);
        chk_if(1, 32'h0040_0000); chk_perf(1, 1);

        // Not taken: 2 -> 1 (mispredicted), then 1 -> 0, then stays at 0
        step(); drive(32'h0040_0024, 32'h0040_0020, 1, 0, 0, 0);
        chk_id(1, 32'h0040_0024);

        step(); drive(32'h0040_0020, 0, 0, 0, 0, 0);
        chk_if(0, 32'h0040_0024); chk_perf(2, 2);

        step(); drive(32'h0040_0024, 32'h0040_0020, 1, 0, 0, 0);
        chk_id(0, 32'h0040_0024);

        step(); drive(32'h0040_0024, 32'h0040_0020, 1, 0, 0, 0);
        chk_id(0, 32'h0040_0024); chk_perf(3, 2);

        // Taken from 0 -> 1: still predicts not-taken (no wrap at 0)
        step(); drive(32'h0040_0024, 32'h0040_0020, 1, 0, 1, 32'h0040_0000);
        chk_id(1, 32'h0040_0000); chk_perf(4, 2);

        step(); drive(32'h0040_0020, 0, 0, 0, 0, 0);
        chk_if(0, 32'h0040_0024); chk_perf(5, 3);

        step(); drive(32'h0040_0024, 32'h0040_0020, 1, 0, 1, 32'h0040_0000);
        chk_id(1, 32'h0040_0000);

        step(); drive(32'h0040_0020, 0, 0, 0, 0, 0);
        chk_if(1, 32'h0040_0000); chk_perf(6, 4);

        // ID_hold with mismatching outcome: no mispredict, no update
        step(); drive(32'h0040_0020, 32'h0040_0020, 1, 1, 0, 0);
        chk_id(0, 32'h0040_0024);

        step(); drive(32'h0040_0020, 32'h0040_0020, 1, 1, 0, 0);
        chk_if(1, 32'h0040_0000); chk_id(0, 32'h0040_0024); chk_perf(6, 4);

        // Alias lookup misses; forced p_taken on a non-branch invalidates idx 8
        step(); drive(32'h0040_0060, 32'h0040_0060, 0, 0, 0, 0);
        chk_if(0, 32'h0040_0064); chk_id(1, 32'h0040_0064);

        step(); drive(32'h0040_0020, 0, 0, 0, 0, 0);
        chk_if(0, 32'h0040_0024); chk_perf(6, 5);

        // Re-allocate, then IF_stall holds the copy
        step(); drive(32'h0040_0020, 32'h0040_0020, 1, 0, 1, 32'h0040_0100);
        chk_id(1, 32'h0040_0100);

        step(); drive(32'h0040_0020, 0, 0, 0, 0, 0);
        chk_if(1, 32'h0040_0100); chk_perf(7, 6);

        step(); bp_if.IF_stall = 1'b1; drive(32'h0040_0000, 0, 0, 1, 0, 0);
        chk_if(0, 32'h0040_0004);

        step(); drive(32'h0040_0000, 32'h0040_0020, 1, 0, 1, 32'h0040_0100);
        chk_id(0, 32'h0040_0100);

        // flushD beats IF_stall
        step(); bp_if.flushD = 1'b1; bp_if.IF_stall = 1'b1;
        drive(32'h0040_0020, 0, 0, 1, 0, 0);
        chk_if(1, 32'h0040_0100); chk_perf(8, 6);

        step(); drive(32'h0040_0000, 32'h0040_0020, 1, 0, 1, 32'h0040_0100);
        chk_id(1, 32'h0040_0100);

        step(); drive(32'h0040_0020, 0, 0, 1, 0, 0);
        chk_if(1, 32'h0040_0100); chk_perf(9, 7);

        // IF_pc+4 wraps at 32 bits
        step(); drive(32'hFFFF_FFFC, 0, 0, 1, 0, 0);
        chk_if(0, 32'h0000_0000);

        // Saturate perf_branches: 2^16+5 not-taken misses
        for (int i = 0; i < 65541; i++) begin
            step(); drive(32'h0040_0000, 32'h0040_0200, 1, 0, 0, 0);
        end
        step(); drive(32'h0040_0020, 0, 0, 1, 0, 0);
        chk_perf(16'hFFFF, 7); chk_if(1, 32'h0040_0100);

        // Asynchronous reset mid-stream: copy holds taken, reset clears it at once
        step(); drive(32'h0040_0020, 0, 0, 0, 0, 0);
        #1 rst_n = 1'b0;
        chk_if(0, 32'h0040_0024); chk_id(0, 32'h4); chk_perf(0, 0);

        step(); rst_n = 1'b1; drive(32'h0040_0020, 0, 0, 1, 0, 0);
        chk_if(0, 32'h0040_0024);

        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- IF-stage dynamic branch predictor: a direct-mapped BTB in which each entry holds a tag, a target and a 2-bit saturating counter.
- Looks up the fetch PC and supplies the predicted next PC to the fetch mux.
- Carries the prediction through its own IF/ID copy. In ID it resolves ID_misprediction and ID_correct_pc, which feed branch_hazard_detector and the PC-redirect mux. It updates the table from ID-stage outcomes.

Parameters:
- INDEX_WIDTH, 4: BTB index bits; ENTRIES = 2**INDEX_WIDTH.
- PERF_WIDTH, 16: width of the performance counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- IF_pc  in  32  fetch PC, word aligned.
- IF_stall  in  1  hold the IF/ID prediction copy.
- flushD  in  1  clear the IF/ID prediction copy.
- IF_pred_taken  out  1  lookup predicts taken.
- IF_pred_target  out  32  predicted next PC.
- ID_pc  in  32  PC of the instruction in ID.
- ID_is_branch  in  1  ID holds beq/bne/j/jal. jr is excluded.
- ID_hold  in  1  ID operands not yet valid (branch_flushE).
- ID_taken  in  1  resolved outcome in ID.
- ID_target  in  32  resolved target in ID.
- ID_misprediction  out  1  redirect required.
- ID_correct_pc  out  32  redirect PC.
- perf_branches  out  PERF_WIDTH  resolved branches.
- perf_mispredicts  out  PERF_WIDTH  mispredictions.

Behaviour:
- Indexing: idx = pc[INDEX_WIDTH+1:2]; tag = pc[31:INDEX_WIDTH+2]. Each entry stores {valid, tag, target[31:0], ctr[1:0]}.
- Lookup (combinational, zero latency):
  - hit = valid & tag match.
  - IF_pred_taken = hit & ctr[1].
  - IF_pred_target = IF_pred_taken ? entry.target : IF_pc+4 (32-bit wrap).
- IF/ID copy {p_taken, p_target}:
  - Reset value is 0/0.
  - flushD clears it to 0/0 and has priority over IF_stall.
  - IF_stall holds the current value.
  - Otherwise it captures the lookup outputs.
- ID resolution (combinational):
  - ID_hold=1: ID_misprediction=0.
  - ID_is_branch=1: ID_misprediction = (p_taken != ID_taken) | (p_taken & ID_taken & p_target != ID_target).
  - ID_is_branch=0: ID_misprediction = p_taken (stale or aliased entry).
  - ID_correct_pc = (ID_is_branch & ID_taken) ? ID_target : ID_pc+4.
- Table update at the clock edge, only when ID_hold=0:
  - Branch, hit at ID_pc, taken: ctr increments, saturating at 3; target <= ID_target.
  - Branch, hit, not taken: ctr decrements, saturating at 0; target unchanged.
  - Branch, miss, taken: allocate and overwrite the slot with valid=1, tag, target=ID_target, ctr=2.
  - Branch, miss, not taken: no change.
  - Non-branch with p_taken=1: clear valid at idx(ID_pc).
- Same-cycle lookup and update to the same index: the lookup sees pre-update contents. There is no bypass.
- Perf counters:
  - perf_branches increments on each update cycle with ID_is_branch=1.
  - perf_mispredicts increments when ID_misprediction=1.
  - Both saturate at all-ones and never wrap.
- Reset (asynchronous, mid-operation included): all valid=0, all ctr=1, IF/ID copy 0, perf counters 0.
  - Consequently IF_pred_taken=0 and IF_pred_target=IF_pc+4.
  - ID_misprediction=0 whenever the copy is 0 and ID_is_branch=0.
  - Table contents are not preserved across reset.
- No X propagation: table arrays are reset explicitly; do not rely on uninitialised RAM.

Test Plan:
- Reset, then IF_pc=0x0040_0010 -> IF_pred_taken=0, IF_pred_target=0x0040_0014. All perf counters read 0.
- Cold taken beq at 0x0040_0020, target 0x0040_0000:
  - ID_misprediction=1 and ID_correct_pc=0x0040_0000.
  - On the next fetch of 0x0040_0020: IF_pred_taken=1, target 0x0040_0000, ctr=2.
- Same branch resolved not-taken twice:
  - First resolution: misprediction=1, correct_pc=0x0040_0024, ctr=1.
  - Second resolution: predicted not-taken, misprediction=0, ctr=0.
  - ctr stays at 0 on further not-taken outcomes.
- Alias 0x0040_0060 (same idx, different tag) -> IF_pred_taken=0. When it resolves as a non-branch after a forced p_taken, misprediction=1, correct_pc=ID_pc+4, and the entry is invalidated.
- ID_hold=1 with a mismatched outcome -> ID_misprediction=0 and no table or perf change. Release hold -> resolution and update occur.
- Priority and saturation:
  - flushD=1 and IF_stall=1 in the same cycle -> the copy clears to 0.
  - Drive 2^16+5 branch resolutions -> perf_branches=0xFFFF.
  - rst_n low mid-stream -> all outputs return to reset values immediately.
